// File: rtl/mips_isa_pkg.sv
// MIPS opcode/func constants, control-flag bundle and the control decoder.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam int REG_RA = 31;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    // Main control decode; unknown opcodes leave every flag low.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = (fn != FN_JR);
                c.jump      = (fn == FN_JR) || (fn == FN_JALR);
            end
            OP_J:   c.jump = 1'b1;
            OP_JAL: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: c.branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c.reg_write = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: c.mem_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Instructions whose rt field is a source operand.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// Bundle of the decode-stage inputs (IF/ID, WB, EX hazard info) and ID/EX outputs.
// Latency: n/a (wiring only).
// Backpressure: i_stall holds ID/EX; o_hazard requests upstream hold.
interface id_stage_hz_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_PC   = 32
);
    logic               i_valid;
    logic [31:0]        i_instruction;
    logic [NB_PC-1:0]   i_pc4;
    logic               i_stall;
    logic               i_flush;
    logic               i_wb_we;
    logic [NB_ADDR-1:0] i_wb_addr;
    logic [NB_DATA-1:0] i_wb_data;
    logic               i_ex_memread;
    logic [NB_ADDR-1:0] i_ex_rt;

    logic               o_hazard;
    logic               o_valid;
    logic [NB_ADDR-1:0] o_rs;
    logic [NB_ADDR-1:0] o_rt;
    logic [NB_ADDR-1:0] o_rd;
    logic [NB_ADDR-1:0] o_dest;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_DATA-1:0] o_imm;
    logic [5:0]         o_opcode;
    logic [5:0]         o_func;
    logic [4:0]         o_shamt;
    logic [25:0]        o_jtarget;
    logic [NB_PC-1:0]   o_pc4;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic               o_branch;
    logic               o_jump;

    modport master (
        output i_valid, i_instruction, i_pc4, i_stall, i_flush,
               i_wb_we, i_wb_addr, i_wb_data, i_ex_memread, i_ex_rt,
        input  o_hazard, o_valid, o_rs, o_rt, o_rd, o_dest, o_data_a, o_data_b,
               o_imm, o_opcode, o_func, o_shamt, o_jtarget, o_pc4,
               o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump
    );

    modport slave (
        input  i_valid, i_instruction, i_pc4, i_stall, i_flush,
               i_wb_we, i_wb_addr, i_wb_data, i_ex_memread, i_ex_rt,
        output o_hazard, o_valid, o_rs, o_rt, o_rd, o_dest, o_data_a, o_data_b,
               o_imm, o_opcode, o_func, o_shamt, o_jtarget, o_pc4,
               o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump
    );
endinterface

// File: rtl/id_stage_hz_gpr_file.sv
// GPR file: two combinational read ports, one write port, optional WB->ID bypass.
// Latency: reads 0 cycles; writes visible next cycle (same cycle when BYPASS=1).
// Backpressure: none; writes are never blocked by stall or flush.
module gpr_file #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32,
    parameter int BYPASS  = 1
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic [NB_ADDR-1:0] rd_addr_a,
    input  logic [NB_ADDR-1:0] rd_addr_b,
    output logic [NB_DATA-1:0] rd_data_a,
    output logic [NB_DATA-1:0] rd_data_b
);

    // Register 0 has no storage; it is the implicit zero.
    logic [NB_DATA-1:0] gpr_q [1:N_REGS-1];
    logic [NB_DATA-1:0] gpr_d [1:N_REGS-1];

    // Next array contents: a single register updated when WB targets it.
    always_comb begin
        gpr_d = gpr_q;
        for (int i = 1; i < N_REGS; i++) begin
            if (wr_en && (wr_addr == NB_ADDR'(i))) begin
                gpr_d[i] = wr_data;
            end
        end
    end

    // Array storage, deliberately not reset.
    always_ff @(posedge clk) begin
        gpr_q <= gpr_d;
    end

    // Read ports; a matching same-cycle write wins when bypass is enabled.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 1; i < N_REGS; i++) begin
            if (rd_addr_a == NB_ADDR'(i)) begin
                rd_data_a = ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_a)) ? wr_data : gpr_q[i];
            end
            if (rd_addr_b == NB_ADDR'(i)) begin
                rd_data_b = ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_b)) ? wr_data : gpr_q[i];
            end
        end
    end

endmodule

// File: rtl/id_stage_hz.sv
// MIPS decode stage: GPR read, field/imm/control decode, load-use detect, ID/EX register.
// Latency: 1 cycle instruction->ID/EX outputs; o_hazard is combinational.
// Backpressure: i_stall holds ID/EX; o_hazard inserts a bubble and stalls PC/IF-ID.
module id_stage_hz
    import mips_isa_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32,
    parameter int BYPASS  = 1,
    parameter int NB_PC   = 32
) (
    input  logic        clk,
    input  logic        i_rst_n,
    id_stage_hz_if.slave bus
);

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic [NB_ADDR-1:0] rd;
        logic [NB_ADDR-1:0] dest;
        logic [NB_DATA-1:0] data_a;
        logic [NB_DATA-1:0] data_b;
        logic [NB_DATA-1:0] imm;
        logic [5:0]         opcode;
        logic [5:0]         func;
        logic [4:0]         shamt;
        logic [25:0]        jtarget;
        logic [NB_PC-1:0]   pc4;
        ctrl_t              ctrl;
    } idex_t;

    idex_t              dec;
    idex_t              idex_d;
    idex_t              idex_q;
    logic [NB_DATA-1:0] rd_data_a;
    logic [NB_DATA-1:0] rd_data_b;
    logic               hazard;
    logic [31:0]        instr;

    assign instr = bus.i_instruction;

    gpr_file #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .N_REGS  (N_REGS),
        .BYPASS  (BYPASS)
    ) u_gpr (
        .clk       (clk),
        .wr_en     (bus.i_wb_we),
        .wr_addr   (bus.i_wb_addr),
        .wr_data   (bus.i_wb_data),
        .rd_addr_a (NB_ADDR'(instr[25:21])),
        .rd_addr_b (NB_ADDR'(instr[20:16])),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    // Decode of the instruction sitting in IF/ID; flags are qualified by i_valid.
    always_comb begin
        dec         = '0;
        dec.valid   = bus.i_valid;
        dec.opcode  = instr[31:26];
        dec.rs      = NB_ADDR'(instr[25:21]);
        dec.rt      = NB_ADDR'(instr[20:16]);
        dec.rd      = NB_ADDR'(instr[15:11]);
        dec.shamt   = instr[10:6];
        dec.func    = instr[5:0];
        dec.jtarget = instr[25:0];
        dec.pc4     = bus.i_pc4;
        dec.data_a  = rd_data_a;
        dec.data_b  = rd_data_b;
        case (instr[31:26])
            OP_ANDI, OP_ORI, OP_XORI: dec.imm = NB_DATA'({16'h0000, instr[15:0]});
            OP_LUI:                   dec.imm = NB_DATA'({instr[15:0], 16'h0000});
            default:                  dec.imm = NB_DATA'({{16{instr[15]}}, instr[15:0]});
        endcase
        if (instr[31:26] == OP_RTYPE) begin
            dec.dest = NB_ADDR'(instr[15:11]);
        end else if (instr[31:26] == OP_JAL) begin
            dec.dest = NB_ADDR'(REG_RA);
        end else begin
            dec.dest = NB_ADDR'(instr[20:16]);
        end
        dec.ctrl = bus.i_valid ? decode_ctrl(instr[31:26], instr[5:0]) : '0;
    end

    // Load-use: the load in EX writes a register this instruction reads.
    always_comb begin
        hazard = bus.i_valid && bus.i_ex_memread && (bus.i_ex_rt != '0) &&
                 ((bus.i_ex_rt == dec.rs) || (uses_rt(dec.opcode) && (bus.i_ex_rt == dec.rt)));
    end

    // ID/EX next state: flush beats stall, stall beats bubble, bubble beats load.
    always_comb begin
        idex_d = idex_q;
        if (bus.i_flush) begin
            idex_d = '0;
        end else if (bus.i_stall) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d.valid = 1'b0;
            idex_d.ctrl  = '0;
        end else begin
            idex_d = dec;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.o_hazard    = hazard;
    assign bus.o_valid     = idex_q.valid;
    assign bus.o_rs        = idex_q.rs;
    assign bus.o_rt        = idex_q.rt;
    assign bus.o_rd        = idex_q.rd;
    assign bus.o_dest      = idex_q.dest;
    assign bus.o_data_a    = idex_q.data_a;
    assign bus.o_data_b    = idex_q.data_b;
    assign bus.o_imm       = idex_q.imm;
    assign bus.o_opcode    = idex_q.opcode;
    assign bus.o_func      = idex_q.func;
    assign bus.o_shamt     = idex_q.shamt;
    assign bus.o_jtarget   = idex_q.jtarget;
    assign bus.o_pc4       = idex_q.pc4;
    assign bus.o_reg_write = idex_q.ctrl.reg_write;
    assign bus.o_mem_read  = idex_q.ctrl.mem_read;
    assign bus.o_mem_write = idex_q.ctrl.mem_write;
    assign bus.o_branch    = idex_q.ctrl.branch;
    assign bus.o_jump      = idex_q.ctrl.jump;

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
Parametrised successor of the MIPS decode stage. Holds the GPR file with WB-to-ID write-first bypass and decodes the instruction fields, extended immediate, destination register and main control flags. Detects load-use hazards and registers everything into the ID/EX pipeline register, which supports a valid bit, hold, bubble insertion and flush. Sits between the IF/ID register and EX.

Parameters:
NB_DATA, 32, datapath and register width
NB_ADDR, 5, register address width
N_REGS, 32, number of GPRs (at most 2**NB_ADDR); register 0 reads as zero
BYPASS, 1, 1 = same-cycle WB write is visible on the ID read; 0 = read returns the old value
NB_PC, 32, width of the PC+4 carried down the pipe

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  i_instruction holds a real instruction
i_instruction  in  32  instruction from IF/ID
i_pc4  in  NB_PC  PC+4 of the instruction
i_stall  in  1  external hold; the ID/EX register keeps its contents
i_flush  in  1  squash the instruction entering EX (taken branch or jump)
i_wb_we  in  1  write-back enable
i_wb_addr  in  NB_ADDR  write-back register
i_wb_data  in  NB_DATA  write-back data
i_ex_memread  in  1  the instruction currently in EX is a load
i_ex_rt  in  NB_ADDR  destination of that load
o_hazard  out  1  combinational load-use stall request to PC and IF/ID
o_valid  out  1  ID/EX entry valid
o_rs, o_rt, o_rd, o_dest  out  NB_ADDR each  register fields; resolved destination
o_data_a, o_data_b  out  NB_DATA each  GPR[rs] and GPR[rt]
o_imm  out  NB_DATA  extended immediate
o_opcode  out  6  opcode field
o_func  out  6  function field
o_shamt  out  5  shift amount field
o_jtarget  out  26  instruction[25:0]
o_pc4  out  NB_PC  registered PC+4
o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump  out  1 each  control flags

Behaviour:
- Field decode: opcode = [31:26] (full 6 bits); rs = [25:21]; rt = [20:16]; rd = [15:11]; shamt = [10:6]; func = [5:0].
- GPR file: writes on posedge clk when i_wb_we=1 and i_wb_addr!=0. Writes occur regardless of stall or flush. Register 0 is never written. There is no reset of the array contents. Reads are combinational.
- Bypass (BYPASS=1): if i_wb_we=1, i_wb_addr equals the read address and the address is non-zero, the read returns i_wb_data.
- Immediate extension:
  - andi/ori/xori (0x0C/0x0D/0x0E): zero-extend.
  - lui (0x0F): {imm,16'b0}.
  - All other opcodes: sign-extend.
- Destination (o_dest): rd for R-type (opcode 0); 31 for jal (0x03); rt otherwise.
- Control flags:
  - reg_write: R-type except jr (func 0x08); opcodes 0x08–0x0F; loads; jal.
  - mem_read (loads): 0x20, 0x21, 0x23, 0x24, 0x25, 0x27.
  - mem_write: 0x28, 0x29, 0x2B.
  - branch: 0x04, 0x05.
  - jump: 0x02, 0x03, or R-type func 0x08/0x09.
  - Unknown opcodes: all flags 0.
- uses_rt = R-type, store or beq/bne.
- o_hazard = i_valid & i_ex_memread & (i_ex_rt!=0) & (i_ex_rt==rs | (uses_rt & i_ex_rt==rt)). Purely combinational, no latency.
- ID/EX register update at posedge, in priority order:
  1. reset: all outputs 0.
  2. i_flush: o_valid=0 and all control flags 0; data fields don't-care (implementation clears them).
  3. i_stall: hold every output.
  4. o_hazard: bubble, i.e. o_valid=0 and flags 0.
  5. Otherwise: load all decoded values; o_valid=i_valid; flags gated with i_valid.
- Latency: one cycle from i_instruction to outputs.
- Invalid entries never carry reg_write, mem_write, branch or jump.
- Flush and stall asserted together: flush wins.
- Reset mid-operation clears the pipeline register immediately (async). The GPR array keeps its contents.

Decomposition:
- Package mips_isa_pkg holds the opcode and func constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LUI, OP_LW…, FN_JR, FN_JALR) and REG_RA=31.
- Sub-module gpr_file (parametrised by NB_DATA, NB_ADDR, N_REGS, BYPASS): two async read ports, one sync write port, bypass logic.
- Decode and control are combinational functions inside id_stage_hz.

Test Plan:
- Reset → all outputs 0. Write r5=0xDEADBEEF, then decode `add r3,r5,r0` → o_data_a=0xDEADBEEF, o_dest=3, o_reg_write=1, o_valid=1, one cycle later.
- Same-cycle bypass: WB writes r7=0x1234 while ID reads r7. BYPASS=1 → o_data_a=0x1234; BYPASS=0 → old value. A write to r0 keeps r0 reading 0.
- Immediates:
  - `addi` imm 0xFFF0 → o_imm=0xFFFFFFF0.
  - `ori` imm 0xFFF0 → 0x0000FFF0.
  - `lui` imm 0x1234 → 0x12340000.
- Load-use: i_ex_memread=1, i_ex_rt=4, ID holds `sw r4,0(r2)` → o_hazard=1 and next-cycle o_valid=0 with all flags 0. With i_ex_rt=0 → no hazard.
- i_stall=1 for 3 cycles with a changing instruction → outputs frozen. i_flush during i_stall → o_valid=0 next cycle.
- `jal` → o_dest=31, o_jump=1, o_reg_write=1. `jr r31` → o_jump=1, o_reg_write=0. Opcode 0x3F → all flags 0.
